// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the RV32IM 5-stage pipe.
// Handles load-use bubbles, taken-branch squashes and multi-cycle DIV/REM.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   ID_RS1/RS2, ID_USES_RS1/2  source operands of the instruction in ID
//   EX_ADD, EX_MR, EX_REG_EN   destination/load info of the instruction in EX
//   EX_DIV                     EX holds a DIV/DIVU/REM/REMU
//   BR_TAKEN                   branch/jump in EX resolved taken
//   CNT_CLR                    clears both event counters
//   PC_STALL, IFID_STALL       hold PC and IF/ID
//   IFID_FLUSH, IDEX_FLUSH     squash IF/ID and ID/EX
//   IDEX_STALL, EXMEM_BUBBLE   hold ID/EX, bubble EX/MEM during division
//   DIV_START, DIV_BUSY        divider start pulse and wait-state flag
//   STALL_CNT, FLUSH_CNT       saturating event counters
module pipeline_hazard_ctrl #(
   parameter int DIV_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_USES_RS1,
   input  logic             ID_USES_RS2,
   input  logic [4:0]       EX_ADD,
   input  logic [1:0]       EX_MR,
   input  logic             EX_REG_EN,
   input  logic             EX_DIV,
   input  logic             BR_TAKEN,
   input  logic             CNT_CLR,
   output logic             PC_STALL,
   output logic             IFID_STALL,
   output logic             IFID_FLUSH,
   output logic             IDEX_STALL,
   output logic             IDEX_FLUSH,
   output logic             EXMEM_BUBBLE,
   output logic             DIV_START,
   output logic             DIV_BUSY,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   localparam int DW = $clog2(DIV_LATENCY);
   localparam logic [DW-1:0] DLOAD = DW'(DIV_LATENCY - 2);

   typedef enum logic {RUN, DIV_WAIT} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic          lu;
   logic          hit1, hit2;

   assign hit1 = ID_USES_RS1 && (ID_RS1 == EX_ADD);
   assign hit2 = ID_USES_RS2 && (ID_RS2 == EX_ADD);
   assign lu   = (EX_MR != 2'b00) && EX_REG_EN &&
                 (EX_ADD != 5'd0) && (hit1 || hit2);

   always_comb begin
      state_nxt    = state;
      dcnt_nxt     = dcnt;
      PC_STALL     = 1'b0;
      IFID_STALL   = 1'b0;
      IFID_FLUSH   = 1'b0;
      IDEX_STALL   = 1'b0;
      IDEX_FLUSH   = 1'b0;
      EXMEM_BUBBLE = 1'b0;
      DIV_START    = 1'b0;
      DIV_BUSY     = 1'b0;
      if (!RESET) begin
         unique case (state)
            RUN: begin
               if (BR_TAKEN) begin
                  IFID_FLUSH = 1'b1;
                  IDEX_FLUSH = 1'b1;
               end else if (EX_DIV) begin
                  DIV_START    = 1'b1;
                  PC_STALL     = 1'b1;
                  IFID_STALL   = 1'b1;
                  IDEX_STALL   = 1'b1;
                  EXMEM_BUBBLE = 1'b1;
                  dcnt_nxt     = DLOAD;
                  state_nxt    = DIV_WAIT;
               end else if (lu) begin
                  PC_STALL   = 1'b1;
                  IFID_STALL = 1'b1;
                  IDEX_FLUSH = 1'b1;
               end
            end
            DIV_WAIT: begin
               DIV_BUSY = 1'b1;
               // Last EX cycle releases the pipe so EX/MEM takes the result.
               if (dcnt != '0) begin
                  PC_STALL     = 1'b1;
                  IFID_STALL   = 1'b1;
                  IDEX_STALL   = 1'b1;
                  EXMEM_BUBBLE = 1'b1;
                  dcnt_nxt     = dcnt - 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= RUN;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET || CNT_CLR) begin
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         if (PC_STALL && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + CNT_W'(1);
         if (IFID_FLUSH && (FLUSH_CNT != '1))
            FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl with a
// cycle model of the hazard rules and literal spot checks.
module tb_pipeline_hazard_ctrl;

   localparam int DL = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          CLK;
   logic          RESET;
   logic [4:0]    ID_RS1, ID_RS2;
   logic          ID_USES_RS1, ID_USES_RS2;
   logic [4:0]    EX_ADD;
   logic [1:0]    EX_MR;
   logic          EX_REG_EN, EX_DIV, BR_TAKEN, CNT_CLR;
   logic          PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL;
   logic          IDEX_FLUSH, EXMEM_BUBBLE, DIV_START, DIV_BUSY;
   logic [CW-1:0] STALL_CNT, FLUSH_CNT;

   int n_chk = 0;
   int n_fail = 0;

   // model state: remaining busy EX cycles of the current division
   int  m_left = 0;
   int  m_stall = 0;
   int  m_flush = 0;
   bit  m_cnt_ok = 0;

   pipeline_hazard_ctrl #(.DIV_LATENCY(DL), .CNT_W(CW)) dut (
      .CLK(CLK), .RESET(RESET),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .EX_ADD(EX_ADD), .EX_MR(EX_MR), .EX_REG_EN(EX_REG_EN),
      .EX_DIV(EX_DIV), .BR_TAKEN(BR_TAKEN), .CNT_CLR(CNT_CLR),
      .PC_STALL(PC_STALL), .IFID_STALL(IFID_STALL),
      .IFID_FLUSH(IFID_FLUSH), .IDEX_STALL(IDEX_STALL),
      .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_BUBBLE(EXMEM_BUBBLE),
      .DIV_START(DIV_START), .DIV_BUSY(DIV_BUSY),
      .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rst, input bit br, input bit dv,
                        input bit clr, input bit [1:0] mr, input bit ren,
                        input bit [4:0] add, input bit u1, input bit [4:0] r1,
                        input bit u2, input bit [4:0] r2);
      RESET = rst; BR_TAKEN = br; EX_DIV = dv; CNT_CLR = clr;
      EX_MR = mr; EX_REG_EN = ren; EX_ADD = add;
      ID_USES_RS1 = u1; ID_RS1 = r1; ID_USES_RS2 = u2; ID_RS2 = r2;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
   endtask

   // compare at negedge, advance model for the coming rising edge
   task automatic tick();
      bit lu, e_pc, e_ifs, e_iff, e_ids, e_idf, e_bub, e_st, e_bsy;
      @(negedge CLK);
      lu = (EX_MR != 0) && EX_REG_EN && (EX_ADD != 0) &&
           ((ID_USES_RS1 && ID_RS1 == EX_ADD) ||
            (ID_USES_RS2 && ID_RS2 == EX_ADD));
      {e_pc, e_ifs, e_iff, e_ids, e_idf, e_bub, e_st, e_bsy} = '0;
      if (!RESET) begin
         if (m_left > 0) begin
            e_bsy = 1;
            if (m_left > 1) {e_pc, e_ifs, e_ids, e_bub} = 4'hF;
         end else if (BR_TAKEN) begin
            e_iff = 1; e_idf = 1;
         end else if (EX_DIV) begin
            e_st = 1; {e_pc, e_ifs, e_ids, e_bub} = 4'hF;
         end else if (lu) begin
            e_pc = 1; e_ifs = 1; e_idf = 1;
         end
      end
      chk("pc_stall", PC_STALL, e_pc);
      chk("ifid_stall", IFID_STALL, e_ifs);
      chk("ifid_flush", IFID_FLUSH, e_iff);
      chk("idex_stall", IDEX_STALL, e_ids);
      chk("idex_flush", IDEX_FLUSH, e_idf);
      chk("exmem_bubble", EXMEM_BUBBLE, e_bub);
      chk("div_start", DIV_START, e_st);
      chk("div_busy", DIV_BUSY, e_bsy);
      if (m_cnt_ok) begin
         chk("stall_cnt", STALL_CNT, m_stall);
         chk("flush_cnt", FLUSH_CNT, m_flush);
      end
      if (RESET) begin
         m_left = 0; m_stall = 0; m_flush = 0; m_cnt_ok = 1;
      end else begin
         if (m_left > 0) m_left--;
         else if (!BR_TAKEN && EX_DIV) m_left = DL - 1;
         if (CNT_CLR) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (e_pc && m_stall < CMAX) m_stall++;
            if (e_iff && m_flush < CMAX) m_flush++;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // reset with branch and divide asserted
      drive(1, 1, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("rst_pc_stall", PC_STALL, 0);
      chk("rst_div_start", DIV_START, 0);
      tick();
      drive(1, 1, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("rst_stall_cnt", STALL_CNT, 0);
      chk("rst_flush_cnt", FLUSH_CNT, 0);
      chk("rst_busy", DIV_BUSY, 0);
      tick();
      idle(); tick();

      // load-use on rs2
      drive(0, 0, 0, 0, 2'b01, 1, 5'd5, 0, 5'd0, 1, 5'd5);
      chk("lu_pc_stall", PC_STALL, 1);
      chk("lu_idex_flush", IDEX_FLUSH, 1);
      tick();
      drive(0, 0, 0, 0, 2'b00, 1, 5'd5, 0, 5'd0, 1, 5'd5);
      chk("lu_release", PC_STALL, 0);
      chk("lu_stall_cnt", STALL_CNT, 1);
      tick();
      // x0 destination never hazards
      drive(0, 0, 0, 0, 2'b01, 1, 5'd0, 0, 5'd0, 1, 5'd0);
      chk("lu_x0", PC_STALL, 0);
      tick();
      // rs1 hazard, unused operand, no write-enable
      drive(0, 0, 0, 0, 2'b10, 1, 5'd7, 1, 5'd7, 0, 5'd0); tick();
      drive(0, 0, 0, 0, 2'b10, 1, 5'd7, 0, 5'd7, 0, 5'd7); tick();
      drive(0, 0, 0, 0, 2'b11, 0, 5'd7, 1, 5'd7, 1, 5'd7); tick();

      // taken branch overrides load-use
      drive(0, 1, 0, 0, 2'b01, 1, 5'd5, 0, 5'd0, 1, 5'd5);
      chk("br_ifid_flush", IFID_FLUSH, 1);
      chk("br_pc_stall", PC_STALL, 0);
      tick();
      idle();
      chk("br_flush_cnt", FLUSH_CNT, 1);
      tick();
      // branch beats divide in RUN
      drive(0, 1, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("br_div_start", DIV_START, 0);
      tick();
      drive(0, 0, 0, 1, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();

      // division sequence, branch ignored in cycle 2
      drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("div_c0_start", DIV_START, 1);
      chk("div_c0_busy", DIV_BUSY, 0);
      tick();
      drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("div_c1_busy", DIV_BUSY, 1);
      chk("div_c1_start", DIV_START, 0);
      tick();
      drive(0, 1, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("div_c2_stall", PC_STALL, 1);
      chk("div_c2_noflush", IFID_FLUSH, 0);
      tick();
      drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("div_c3_release", PC_STALL, 0);
      chk("div_c3_busy", DIV_BUSY, 1);
      tick();
      idle();
      chk("div_stall_cnt", STALL_CNT, 3);
      tick();

      // back-to-back divides
      for (int i = 0; i < 2 * DL; i++) begin
         drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
         tick();
      end
      idle(); tick();

      // reset in the middle of a division
      drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
      drive(0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
      drive(1, 0, 1, 0, 2'b00, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      chk("mid_rst_stall", PC_STALL, 0);
      tick();
      idle();
      chk("after_rst_busy", DIV_BUSY, 0);
      chk("after_rst_stall", PC_STALL, 0);
      tick();

      // saturation
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 2'b01, 1, 5'd9, 1, 5'd9, 0, 5'd0);
         tick();
      end
      idle();
      chk("sat_stall_cnt", STALL_CNT, 15);
      tick();
      drive(0, 0, 0, 1, 2'b01, 1, 5'd9, 1, 5'd9, 0, 5'd0); tick();
      idle();
      chk("clr_stall_cnt", STALL_CNT, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
